wear_level_scanner: RTL and testbench
=====================================

Name: wear_level_scanner

Overview:
- Read-side consumer of the per-block erase-count table. It accepts the packed erase-count bus and an eligibility mask.
- On request, it scans every block sequentially, one block per clock. It reports the least-worn eligible block, min/max erase counts, their spread and a wear-imbalance alarm.
- Sits between the erase-count table and the block allocator / garbage-collection victim selector.

Parameters:
- BLOCKS, 64, number of erase blocks; must be ≥2.
- CNT_W, 16, erase-count width per block.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- erase_count_flat  input  BLOCKS*CNT_W  packed counts; block g at bits [g*CNT_W +: CNT_W]
- eligible_mask  input  BLOCKS  bit g=1: block g is a candidate (free/allocatable)
- spread_thresh  input  CNT_W  alarm threshold on max-min
- scan_req  input  1  start-scan request, level sampled in IDLE only
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse; result outputs updated this cycle
- found  output  1  at least one eligible block seen in last scan
- min_block_id  output  $clog2(BLOCKS)  eligible block with lowest count
- min_count  output  CNT_W  count of min_block_id
- max_count  output  CNT_W  highest count among eligible blocks
- spread  output  CNT_W  max_count - min_count
- wear_alarm  output  1  spread > spread_thresh (strict), registered at done

Behaviour:
- FSM states: IDLE, SCAN, DONE.
  - IDLE→SCAN when scan_req=1.
  - SCAN→DONE after index BLOCKS-1 is examined.
  - DONE→IDLE unconditionally.
- scan_req is ignored in SCAN and DONE; no queuing.
  - A request held high through DONE starts a new scan from IDLE on the following cycle.
- Timing: scan_req sampled high in IDLE at edge T.
  - busy=1 from T+1 through T+BLOCKS.
  - Index i is examined in cycle T+1+i.
  - done=1 and results valid in cycle T+BLOCKS+1; busy=0 in that cycle.
  - Total latency: BLOCKS+1 cycles request-to-done.
- Per-block examination reads erase_count_flat and eligible_mask live at the current index; no snapshot.
  - A count that changes mid-scan is seen at its value when its index is visited.
- Accumulators are cleared on entry to SCAN: acc_min=all-ones, acc_max=0, acc_found=0, acc_id=0.
- For an eligible block:
  - if !acc_found or cnt < acc_min, update acc_min/acc_id.
  - if !acc_found or cnt > acc_max, update acc_max.
  - then set acc_found=1.
- Tie-break: strict compares, so the lowest index wins for equal minimum counts.
- Result registers load only at the DONE transition and hold until the next done.
  - Normal case: found=acc_found, min_block_id=acc_id, min_count=acc_min, max_count=acc_max, spread=acc_max-acc_min (never wraps, since max≥min).
  - No eligible block: found=0, min_block_id=0, min_count=0, max_count=0, spread=0, wear_alarm=0.
- Count at all-ones (saturated upstream) is treated as an ordinary value.
- Reset (any state, including mid-scan): FSM→IDLE; busy=0, done=0, found=0, min_block_id=0, min_count=0, max_count=0, spread=0, wear_alarm=0; accumulators cleared. No done pulse for an aborted scan.
- Index counter is $clog2(BLOCKS) bits. For non-power-of-2 BLOCKS, termination compares against BLOCKS-1, not wrap.

Decomposition:
- Shared package wl_pkg:
  - CNT_W default constant.
  - Scanner state enum {IDLE, SCAN, DONE}.
  - blk_id width helper.
- One natural sub-module: wl_minmax_acc. It holds the compare/accumulate registers (clear, valid-in, count, index → min/id/max/found). The FSM and index counter stay in the top.

Test Plan:
- BLOCKS=8, counts {5,3,9,3,7,1,4,2}, mask=0xFF, thresh=7, pulse scan_req → done exactly 9 cycles later; min_block_id=5, min_count=1, max_count=9, spread=8, wear_alarm=1, found=1.
- Same counts, mask=0x0A (blocks 1,3) → min_block_id=1 (tie, lowest index), min_count=3, max_count=3, spread=0, wear_alarm=0.
- mask=0x00 → found=0, all result fields 0, done still pulses at cycle 9.
- scan_req held high continuously → done pulses every 10 cycles; scan_req pulses during busy produce no extra done.
- Assert reset at cycle 4 of a scan → next cycle busy=0, done never pulses, results all 0; a fresh scan_req then gives correct results.
- During scan, change block 7 count from 2 to 0 in the cycle before index 7 is examined, with mask=0xFF → min_block_id=7, min_count=0; the same change made after index 7 is examined → min_block_id=5.

Source files
------------

// File: rtl/wl_pkg.sv
// Shared definitions for the wear-level scanner: default count width,
// scanner FSM state encoding and the block-id width helper.
// Ports: none (package).
package wl_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Width of a block index; never narrower than one bit.
  function automatic int blk_id_w(input int blocks);
    return (blocks > 1) ? $clog2(blocks) : 1;
  endfunction

endpackage

// File: rtl/wl_minmax_acc.sv
// Min/max compare-accumulate registers for one scan pass.
// Ports: clr (reinitialise), in_vld/in_cnt/in_id (one eligible sample per cycle),
//        *_nxt (accumulator values including this cycle's sample).
import wl_pkg::*;

module wl_minmax_acc #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ID_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [ID_W-1:0]  in_id,
  output logic             found_nxt,
  output logic [ID_W-1:0]  id_nxt,
  output logic [CNT_W-1:0] min_nxt,
  output logic [CNT_W-1:0] max_nxt
);

  logic             found_q, found_d;
  logic [ID_W-1:0]  id_q,    id_d;
  logic [CNT_W-1:0] min_q,   min_d;
  logic [CNT_W-1:0] max_q,   max_d;

  always_comb begin
    found_d = found_q;
    id_d    = id_q;
    min_d   = min_q;
    max_d   = max_q;
    if (clr) begin
      found_d = 1'b0;
      id_d    = '0;
      min_d   = '1;
      max_d   = '0;
    end else if (in_vld) begin
      // Strict compares: an equal count never displaces an earlier (lower) index.
      if (!found_q || (in_cnt < min_q)) begin
        min_d = in_cnt;
        id_d  = in_id;
      end
      if (!found_q || (in_cnt > max_q)) begin
        max_d = in_cnt;
      end
      found_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      found_q <= 1'b0;
      id_q    <= '0;
      min_q   <= '1;
      max_q   <= '0;
    end else begin
      found_q <= found_d;
      id_q    <= id_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  // The last block of a scan is folded in on the same edge the results load,
  // so the top consumes the next-state values rather than the registers.
  assign found_nxt = found_d;
  assign id_nxt    = id_d;
  assign min_nxt   = min_d;
  assign max_nxt   = max_d;

endmodule

// File: rtl/wear_level_scanner.sv
// Sequential scan of the per-block erase-count table, one block per clock,
// reporting least-worn eligible block, min/max counts, spread and alarm.
// Ports: erase_count_flat/eligible_mask/spread_thresh (live inputs), scan_req,
//        busy, done (1-cycle pulse), found/min_block_id/min_count/max_count/spread/wear_alarm.
import wl_pkg::*;

module wear_level_scanner #(
  parameter int BLOCKS = 64,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BLOCKS*CNT_W-1:0]   erase_count_flat,
  input  logic [BLOCKS-1:0]         eligible_mask,
  input  logic [CNT_W-1:0]          spread_thresh,
  input  logic                      scan_req,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
  output logic [blk_id_w(BLOCKS)-1:0] min_block_id,
  output logic [CNT_W-1:0]          min_count,
  output logic [CNT_W-1:0]          max_count,
  output logic [CNT_W-1:0]          spread,
  output logic                      wear_alarm
);

  localparam int ID_W = blk_id_w(BLOCKS);
  // Explicit terminal index so non-power-of-2 block counts stop correctly.
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(BLOCKS - 1);

  scan_state_e      state_q, state_d;
  logic [ID_W-1:0]  idx_q,   idx_d;
  logic             found_q, found_d;
  logic [ID_W-1:0]  id_q,    id_d;
  logic [CNT_W-1:0] min_q,   min_d;
  logic [CNT_W-1:0] max_q,   max_d;
  logic [CNT_W-1:0] spread_q, spread_d;
  logic             alarm_q, alarm_d;

  logic             acc_clr;
  logic             acc_vld;
  logic             res_ld;
  logic [CNT_W-1:0] cur_cnt;
  logic             acc_found;
  logic [ID_W-1:0]  acc_id;
  logic [CNT_W-1:0] acc_min;
  logic [CNT_W-1:0] acc_max;
  logic [CNT_W-1:0] acc_spread;

  // Inputs are read live at the current index; no snapshot is taken.
  assign cur_cnt = erase_count_flat[idx_q*CNT_W +: CNT_W];

  wl_minmax_acc #(
    .CNT_W (CNT_W),
    .ID_W  (ID_W)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .clr       (acc_clr),
    .in_vld    (acc_vld),
    .in_cnt    (cur_cnt),
    .in_id     (idx_q),
    .found_nxt (acc_found),
    .id_nxt    (acc_id),
    .min_nxt   (acc_min),
    .max_nxt   (acc_max)
  );

  // max >= min whenever anything was found, so this never wraps when used.
  assign acc_spread = acc_max - acc_min;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_clr = 1'b0;
    acc_vld = 1'b0;
    res_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_req) begin
          state_d = SCAN;
          idx_d   = '0;
          acc_clr = 1'b1;
        end
      end
      SCAN: begin
        acc_vld = eligible_mask[idx_q];
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          res_ld  = 1'b1;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    found_d  = found_q;
    id_d     = id_q;
    min_d    = min_q;
    max_d    = max_q;
    spread_d = spread_q;
    alarm_d  = alarm_q;
    if (res_ld) begin
      if (acc_found) begin
        found_d  = 1'b1;
        id_d     = acc_id;
        min_d    = acc_min;
        max_d    = acc_max;
        spread_d = acc_spread;
        alarm_d  = (acc_spread > spread_thresh);
      end else begin
        // Empty scan reports all-zero rather than the accumulator init values.
        found_d  = 1'b0;
        id_d     = '0;
        min_d    = '0;
        max_d    = '0;
        spread_d = '0;
        alarm_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      found_q  <= 1'b0;
      id_q     <= '0;
      min_q    <= '0;
      max_q    <= '0;
      spread_q <= '0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      found_q  <= found_d;
      id_q     <= id_d;
      min_q    <= min_d;
      max_q    <= max_d;
      spread_q <= spread_d;
      alarm_q  <= alarm_d;
    end
  end

  assign busy         = (state_q == SCAN);
  assign done         = (state_q == DONE);
  assign found        = found_q;
  assign min_block_id = id_q;
  assign min_count    = min_q;
  assign max_count    = max_q;
  assign spread       = spread_q;
  assign wear_alarm   = alarm_q;

endmodule

// File: tb/tb_wear_level_scanner.sv
module tb_wear_level_scanner;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] erase_count_flat;
  logic [7:0]   eligible_mask;
  logic [15:0]  spread_thresh;
  logic         scan_req;
  logic         busy;
  logic         done;
  logic         found;
  logic [2:0]   min_block_id;
  logic [15:0]  min_count;
  logic [15:0]  max_count;
  logic [15:0]  spread;
  logic         wear_alarm;

  logic [52:0]  res;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  wear_level_scanner #(.BLOCKS(8), .CNT_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .erase_count_flat (erase_count_flat),
    .eligible_mask    (eligible_mask),
    .spread_thresh    (spread_thresh),
    .scan_req         (scan_req),
    .busy             (busy),
    .done             (done),
    .found            (found),
    .min_block_id     (min_block_id),
    .min_count        (min_count),
    .max_count        (max_count),
    .spread           (spread),
    .wear_alarm       (wear_alarm)
  );

  assign res = {found, min_block_id, min_count, max_count, spread, wear_alarm};

  function automatic logic [52:0] ev(input logic f, input logic [2:0] id,
                                     input logic [15:0] mn, input logic [15:0] mx,
                                     input logic [15:0] sp, input logic al);
    return {f, id, mn, mx, sp, al};
  endfunction

  task automatic set_default_counts();
    logic [15:0] c [8];
    c = '{16'd5, 16'd3, 16'd9, 16'd3, 16'd7, 16'd1, 16'd4, 16'd2};
    for (int g = 0; g < 8; g++) erase_count_flat[g*16 +: 16] = c[g];
  endtask

  // Pulse scan_req for one cycle, then watch 30 cycles. lat is the cycle index
  // (1 = first cycle after the sampling edge) of the first done.
  task automatic run_scan(input int chg_cyc, input logic [15:0] chg_val,
                          output int lat, output int ndone);
    lat = -1;
    ndone = 0;
    @(negedge clk);
    scan_req = 1'b1;
    @(posedge clk);
    #1 scan_req = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == chg_cyc) erase_count_flat[7*16 +: 16] = chg_val;
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scan_req = 1'b0;
    eligible_mask = 8'hFF;
    spread_thresh = 16'd7;
    set_default_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({busy, done, res} !== 55'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", {busy, done, res});
    end
    reset = 1'b0;
  endtask

  task automatic test_full_mask();
    int lat, nd;
    eligible_mask = 8'hFF;
    spread_thresh = 16'd7;
    run_scan(0, 16'd0, lat, nd);
    n_chk++;
    if (lat !== 9) begin n_fail++; $display("FAIL full_latency: got %0d want 9", lat); end
    n_chk++;
    if (nd !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", nd); end
    n_chk++;
    if (res !== ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b1)) begin
      n_fail++;
      $display("FAIL full_results: got %h want %h", res, ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b1));
    end
  endtask

  task automatic test_thresh_equal();
    int lat, nd;
    spread_thresh = 16'd8;
    run_scan(0, 16'd0, lat, nd);
    n_chk++;
    if (res !== ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b0)) begin
      n_fail++;
      $display("FAIL thresh_equal: got %h want %h", res, ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b0));
    end
    spread_thresh = 16'd7;
  endtask

  task automatic test_tie_subset();
    int lat, nd;
    eligible_mask = 8'h0A;
    run_scan(0, 16'd0, lat, nd);
    n_chk++;
    if (res !== ev(1'b1, 3'd1, 16'd3, 16'd3, 16'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL tie_subset: got %h want %h", res, ev(1'b1, 3'd1, 16'd3, 16'd3, 16'd0, 1'b0));
    end
  endtask

  task automatic test_empty();
    int lat, nd;
    eligible_mask = 8'h00;
    run_scan(0, 16'd0, lat, nd);
    n_chk++;
    if (lat !== 9) begin n_fail++; $display("FAIL empty_latency: got %0d want 9", lat); end
    n_chk++;
    if (res !== 53'd0) begin n_fail++; $display("FAIL empty_results: got %h want 0", res); end
  endtask

  task automatic test_saturated();
    int lat, nd;
    eligible_mask = 8'h01;
    erase_count_flat[0 +: 16] = 16'hFFFF;
    run_scan(0, 16'd0, lat, nd);
    n_chk++;
    if (res !== ev(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL saturated: got %h want %h", res, ev(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0));
    end
    set_default_counts();
    eligible_mask = 8'hFF;
  endtask

  task automatic test_back_to_back();
    int t [3];
    int k = 0;
    @(negedge clk);
    scan_req = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (done && k < 3) begin
        t[k] = n;
        k++;
      end
    end
    scan_req = 1'b0;
    repeat (12) @(negedge clk);
    n_chk++;
    if (k !== 3) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d want 3", k);
    end else begin
      n_chk++;
      if (t[1] - t[0] !== 10) begin n_fail++; $display("FAIL b2b_period_1: got %0d want 10", t[1] - t[0]); end
      n_chk++;
      if (t[2] - t[1] !== 10) begin n_fail++; $display("FAIL b2b_period_2: got %0d want 10", t[2] - t[1]); end
    end
    n_chk++;
    if (res !== ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b1)) begin
      n_fail++;
      $display("FAIL b2b_results: got %h want %h", res, ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b1));
    end
  endtask

  task automatic test_req_during_busy();
    int lat = -1;
    int nd = 0;
    @(negedge clk);
    scan_req = 1'b1;
    @(posedge clk);
    #1 scan_req = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      scan_req = (n == 3) || (n == 5);
      if (done) begin
        nd++;
        if (lat < 0) lat = n;
      end
    end
    scan_req = 1'b0;
    n_chk++;
    if (nd !== 1) begin n_fail++; $display("FAIL busy_req_done_count: got %0d want 1", nd); end
    n_chk++;
    if (lat !== 9) begin n_fail++; $display("FAIL busy_req_latency: got %0d want 9", lat); end
  endtask

  task automatic test_reset_mid_scan();
    int nd = 0;
    int lat;
    @(negedge clk);
    scan_req = 1'b1;
    @(posedge clk);
    #1 scan_req = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({busy, done, res} !== 55'd0) begin
      n_fail++;
      $display("FAIL reset_mid_scan_state: got %h want 0", {busy, done, res});
    end
    reset = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_chk++;
    if (nd !== 0) begin n_fail++; $display("FAIL reset_abort_done: got %0d want 0", nd); end
    run_scan(0, 16'd0, lat, nd);
    n_chk++;
    if (res !== ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b1)) begin
      n_fail++;
      $display("FAIL post_reset_scan: got %h want %h", res, ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b1));
    end
  endtask

  task automatic test_live_update();
    int lat, nd;
    // Index 7 is examined in cycle 8; changing at cycle 7 is seen.
    run_scan(7, 16'd0, lat, nd);
    n_chk++;
    if (res !== ev(1'b1, 3'd7, 16'd0, 16'd9, 16'd9, 1'b1)) begin
      n_fail++;
      $display("FAIL live_before: got %h want %h", res, ev(1'b1, 3'd7, 16'd0, 16'd9, 16'd9, 1'b1));
    end
    set_default_counts();
    run_scan(9, 16'd0, lat, nd);
    n_chk++;
    if (res !== ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b1)) begin
      n_fail++;
      $display("FAIL live_after: got %h want %h", res, ev(1'b1, 3'd5, 16'd1, 16'd9, 16'd8, 1'b1));
    end
    set_default_counts();
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_thresh_equal();
    test_tie_subset();
    test_empty();
    test_saturated();
    test_back_to_back();
    test_req_during_busy();
    test_reset_mid_scan();
    test_live_update();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
